// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage (port 0)
// and the branch-compare unit (port 1). Round-robin grant, registered issue
// stage driving the ALU, one-entry response buffer per port.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // request port 0 (execute stage)
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    // request port 1 (branch compare)
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    // response port 0
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_data_o,
    output logic              rsp0_zero_o,
    // response port 1
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_data_o,
    output logic              rsp1_zero_o,
    // ALU interface
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_zero_i
);

    logic              r_stage_valid;
    logic              r_stage_owner;
    logic              r_last_grant;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp0_data;
    logic [DATA_W-1:0] r_rsp1_data;
    logic              r_rsp0_zero;
    logic              r_rsp1_zero;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic [DATA_W-1:0] r_alu_data1;
    logic [DATA_W-1:0] r_alu_data2;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_cand0;
    logic              w_cand1;
    logic              w_gnt0;
    logic              w_gnt1;

    // Eligibility and round-robin grant; a port whose op is in flight or whose
    // buffer stays full this cycle cannot be granted, and nothing is granted in reset.
    always_comb begin
        w_elig0 = !(r_stage_valid && !r_stage_owner) && (!r_rsp0_valid || rsp0_ready_i);
        w_elig1 = !(r_stage_valid &&  r_stage_owner) && (!r_rsp1_valid || rsp1_ready_i);
        w_cand0 = rst_i && req0_valid_i && w_elig0;
        w_cand1 = rst_i && req1_valid_i && w_elig1;
        w_gnt0  = w_cand0 && (!w_cand1 || r_last_grant);
        w_gnt1  = w_cand1 && (!w_cand0 || !r_last_grant);
    end

    // Issue stage, grant history and per-port response buffers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stage_valid <= 1'b0;
            r_stage_owner <= 1'b0;
            r_last_grant  <= 1'b1;
            r_alu_ctrl    <= '0;
            r_alu_data1   <= '0;
            r_alu_data2   <= '0;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_data   <= '0;
            r_rsp1_data   <= '0;
            r_rsp0_zero   <= 1'b0;
            r_rsp1_zero   <= 1'b0;
        end else begin
            r_stage_valid <= w_gnt0 || w_gnt1;
            if (w_gnt0) begin
                r_stage_owner <= 1'b0;
                r_last_grant  <= 1'b0;
                r_alu_ctrl    <= req0_ctrl_i;
                r_alu_data1   <= req0_a_i;
                r_alu_data2   <= req0_b_i;
            end else if (w_gnt1) begin
                r_stage_owner <= 1'b1;
                r_last_grant  <= 1'b1;
                r_alu_ctrl    <= req1_ctrl_i;
                r_alu_data1   <= req1_a_i;
                r_alu_data2   <= req1_b_i;
            end

            // A reload at the pop edge keeps valid high with the new result.
            if (r_stage_valid && !r_stage_owner) begin
                r_rsp0_valid <= 1'b1;
                r_rsp0_data  <= alu_data_i;
                r_rsp0_zero  <= alu_zero_i;
            end else if (r_rsp0_valid && rsp0_ready_i) begin
                r_rsp0_valid <= 1'b0;
            end

            if (r_stage_valid && r_stage_owner) begin
                r_rsp1_valid <= 1'b1;
                r_rsp1_data  <= alu_data_i;
                r_rsp1_zero  <= alu_zero_i;
            end else if (r_rsp1_valid && rsp1_ready_i) begin
                r_rsp1_valid <= 1'b0;
            end
        end
    end

    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;
    assign rsp0_valid_o = r_rsp0_valid;
    assign rsp1_valid_o = r_rsp1_valid;
    assign rsp0_data_o  = r_rsp0_data;
    assign rsp1_data_o  = r_rsp1_data;
    assign rsp0_zero_o  = r_rsp0_zero;
    assign rsp1_zero_o  = r_rsp1_zero;
    assign alu_ctrl_o   = r_alu_ctrl;
    assign alu_data1_o  = r_alu_data1;
    assign alu_data2_o  = r_alu_data2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_zero, rsp1_zero;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_d1, alu_d2, alu_res;
    logic        alu_z;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_ctrl_i(req0_ctrl),
        .req0_a_i(req0_a), .req0_b_i(req0_b),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_ctrl_i(req1_ctrl),
        .req1_a_i(req1_a), .req1_b_i(req1_b),
        .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_data_o(rsp0_data),
        .rsp0_zero_o(rsp0_zero),
        .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_data_o(rsp1_data),
        .rsp1_zero_o(rsp1_zero),
        .alu_ctrl_o(alu_ctrl), .alu_data1_o(alu_d1), .alu_data2_o(alu_d2),
        .alu_data_i(alu_res), .alu_zero_i(alu_z)
    );

    // Behavioural ALU: zero is the BEQ/BNE decision for branch op-codes.
    always_comb begin
        alu_res = '0;
        alu_z   = 1'b0;
        case (alu_ctrl)
            4'd0: alu_res = alu_d1 + alu_d2;
            4'd1: alu_res = alu_d1 - alu_d2;
            4'd2: alu_res = alu_d1 & alu_d2;
            4'd3: alu_res = alu_d1 | alu_d2;
            4'd4: alu_res = {31'd0, $signed(alu_d1) < $signed(alu_d2)};
            4'd5: alu_res = alu_d1 ^ alu_d2;
            4'd6: alu_res = alu_d1 << alu_d2[4:0];
            4'd7: alu_res = alu_d1 >> alu_d2[4:0];
            4'd8: alu_res = $signed(alu_d1) >>> alu_d2[4:0];
            default: alu_res = '0;
        endcase
        if (alu_ctrl >= 4'd9) alu_z = (alu_d1 != alu_d2);
        else                  alu_z = (alu_res == 32'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #12;
        n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got %0h exp 0", req0_ready); end
        n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready1 got %0h exp 0", req1_ready); end
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 00", {rsp0_valid, rsp1_valid}); end
        n_vec++; if ({alu_ctrl, alu_d1, alu_d2} !== 68'd0) begin n_err++; $display("FAIL reset_alu got %h/%h/%h exp 0", alu_ctrl, alu_d1, alu_d2); end
        n_vec++; if ({rsp0_data, rsp0_zero, rsp1_data, rsp1_zero} !== 66'd0) begin n_err++; $display("FAIL reset_rsp_data got %h %h exp 0", rsp0_data, rsp1_data); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        rst_i = 1'b1;
    endtask

    task automatic test_add();
        cyc();
        req0_valid = 1'b1; req0_ctrl = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL add_ready got %0h exp 1", req0_ready); end
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid got %0h exp 0", rsp0_valid); end
        n_vec++; if ({alu_ctrl, alu_d1, alu_d2} !== {4'd0, 32'd5, 32'd7}) begin n_err++; $display("FAIL add_alu_in got %h/%h/%h exp 0/5/7", alu_ctrl, alu_d1, alu_d2); end
        cyc();
        @(negedge clk);
        n_vec++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %0h exp 1", rsp0_valid); end
        n_vec++; if (rsp0_data !== 32'd12) begin n_err++; $display("FAIL add_data got %0h exp c", rsp0_data); end
        n_vec++; if (rsp0_zero !== 1'b0) begin n_err++; $display("FAIL add_zero got %0h exp 0", rsp0_zero); end
        cyc();
        @(negedge clk);
        n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL add_pop got %0h exp 0", rsp0_valid); end
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        req0_valid = 1'b1; req0_ctrl = 4'd1; req0_a = 32'd9;    req0_b = 32'd4;
        req1_valid = 1'b1; req1_ctrl = 4'd2; req1_a = 32'hF0;   req1_b = 32'h3C;
        @(negedge clk);
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL tie_first_grant got %b exp 10", {req0_ready, req1_ready}); end
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL tie_second_grant got %b exp 01", {req0_ready, req1_ready}); end
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_err++; $display("FAIL tie_rsp0_valid got %b exp 10", {rsp0_valid, rsp1_valid}); end
        n_vec++; if (rsp0_data !== 32'd5) begin n_err++; $display("FAIL tie_rsp0_data got %0h exp 5", rsp0_data); end
        cyc();
        @(negedge clk);
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin n_err++; $display("FAIL tie_rsp1_valid got %b exp 01", {rsp0_valid, rsp1_valid}); end
        n_vec++; if (rsp1_data !== 32'h30) begin n_err++; $display("FAIL tie_rsp1_data got %0h exp 30", rsp1_data); end
    endtask

    task automatic test_backpressure();
        cyc();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_ctrl = 4'd0; req0_a = 32'd10; req0_b = 32'd20;
        @(negedge clk);
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_ready got %0h exp 1", req0_ready); end
        cyc();
        req0_valid = 1'b0;
        cyc();
        req0_valid = 1'b1; req0_ctrl = 4'd1; req0_a = 32'd50; req0_b = 32'd8;
        req1_valid = 1'b1; req1_ctrl = 4'd0; req1_a = 32'd1;  req1_b = 32'd1;
        @(negedge clk);
        n_vec++; if ({rsp0_valid, rsp0_data} !== {1'b1, 32'd30}) begin n_err++; $display("FAIL bp_rsp0_a got %0h/%0h exp 1/1e", rsp0_valid, rsp0_data); end
        n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL bp_grant got %b exp 01", {req0_ready, req1_ready}); end
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_block got %0h exp 0", req0_ready); end
        n_vec++; if ({rsp0_valid, rsp0_data} !== {1'b1, 32'd30}) begin n_err++; $display("FAIL bp_rsp0_b got %0h/%0h exp 1/1e", rsp0_valid, rsp0_data); end
        cyc();
        @(negedge clk);
        n_vec++; if ({rsp1_valid, rsp1_data} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL bp_rsp1 got %0h/%0h exp 1/2", rsp1_valid, rsp1_data); end
        n_vec++; if ({rsp0_valid, rsp0_data, req0_ready} !== {1'b1, 32'd30, 1'b0}) begin n_err++; $display("FAIL bp_rsp0_c got %0h/%0h rdy %0h exp 1/1e rdy 0", rsp0_valid, rsp0_data, req0_ready); end
        rsp0_ready = 1'b1;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_pop_grant got %0h exp 1", req0_ready); end
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL bp_popped got %0h exp 0", rsp0_valid); end
        cyc();
        @(negedge clk);
        n_vec++; if ({rsp0_valid, rsp0_data} !== {1'b1, 32'd42}) begin n_err++; $display("FAIL bp_rsp0_new got %0h/%0h exp 1/2a", rsp0_valid, rsp0_data); end
    endtask

    task automatic test_ops();
        logic [3:0]  ops   [4];
        logic [31:0] va    [4];
        logic [31:0] vb    [4];
        logic [31:0] edata [4];
        logic        ezero [4];
        ops[0] = 4'd5;  va[0] = 32'h1234;     vb[0] = 32'h1234; edata[0] = 32'd0; ezero[0] = 1'b1;
        ops[1] = 4'd9;  va[1] = 32'd3;        vb[1] = 32'd4;    edata[1] = 32'd0; ezero[1] = 1'b1;
        ops[2] = 4'd4;  va[2] = 32'hFFFFFFFF; vb[2] = 32'd1;    edata[2] = 32'd1; ezero[2] = 1'b0;
        ops[3] = 4'd12; va[3] = 32'd5;        vb[3] = 32'd5;    edata[3] = 32'd0; ezero[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            req1_valid = 1'b1; req1_ctrl = ops[i]; req1_a = va[i]; req1_b = vb[i];
            @(negedge clk);
            n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL ops%0d_ready got %0h exp 1", i, req1_ready); end
            cyc();
            req1_valid = 1'b0;
            @(negedge clk);
            n_vec++; if (alu_ctrl !== ops[i]) begin n_err++; $display("FAIL ops%0d_ctrl got %0h exp %0h", i, alu_ctrl, ops[i]); end
            cyc();
            @(negedge clk);
            n_vec++; if ({rsp1_valid, rsp1_data, rsp1_zero} !== {1'b1, edata[i], ezero[i]}) begin
                n_err++; $display("FAIL ops%0d_rsp got v%0h d%0h z%0h exp v1 d%0h z%0h", i, rsp1_valid, rsp1_data, rsp1_zero, edata[i], ezero[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_d;
        do_reset();
        req0_valid = 1'b1; req0_ctrl = 4'd0; req0_a = 32'd0;    req0_b = 32'd1000;
        req1_valid = 1'b1; req1_ctrl = 4'd1; req1_a = 32'd1000; req1_b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                n_vec++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL rr_grant%0d got %b", i, {req0_ready, req1_ready});
                end
            end
            if (i >= 2) begin
                exp_d = (i % 2 == 0) ? 32'(1000 + i - 2) : 32'(1000 - (i - 2));
                if (i % 2 == 0) begin
                    n_vec++; if ({rsp0_valid, rsp1_valid, rsp0_data} !== {2'b10, exp_d}) begin
                        n_err++; $display("FAIL rr_rsp%0d got v%b d%0d exp v10 d%0d", i, {rsp0_valid, rsp1_valid}, rsp0_data, exp_d);
                    end
                end else begin
                    n_vec++; if ({rsp0_valid, rsp1_valid, rsp1_data} !== {2'b01, exp_d}) begin
                        n_err++; $display("FAIL rr_rsp%0d got v%b d%0d exp v01 d%0d", i, {rsp0_valid, rsp1_valid}, rsp1_data, exp_d);
                    end
                end
            end
            cyc();
            if (i < 8) begin
                if (i % 2 == 0) req0_a = 32'(i + 2);
                else            req1_b = 32'(i + 2);
            end
            if (i == 7) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_op();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_ctrl = 4'd0; req1_a = 32'd7; req1_b = 32'd7;
        cyc();
        req1_valid = 1'b0;
        cyc();
        req0_valid = 1'b1; req0_ctrl = 4'd0; req0_a = 32'd2; req0_b = 32'd3;
        @(negedge clk);
        n_vec++; if ({rsp1_valid, req0_ready} !== 2'b11) begin n_err++; $display("FAIL rmo_setup got %b exp 11", {rsp1_valid, req0_ready}); end
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        rst_i = 1'b0;
        #1;
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rmo_rsp_valid got %b exp 00", {rsp0_valid, rsp1_valid}); end
        n_vec++; if ({alu_ctrl, alu_d1, alu_d2} !== 68'd0) begin n_err++; $display("FAIL rmo_alu got %h/%h/%h exp 0", alu_ctrl, alu_d1, alu_d2); end
        n_vec++; if ({req1_ready, rsp1_data} !== 33'd0) begin n_err++; $display("FAIL rmo_ready_data got %0h/%0h exp 0/0", req1_ready, rsp1_data); end
        req1_valid = 1'b0;
        cyc();
        rst_i = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rmo_after%0d got %b exp 00", i, {rsp0_valid, rsp1_valid}); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_tie_after_reset();
        test_backpressure();
        test_ops();
        test_round_robin();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
